// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: load-use stalls, multi-cycle mult/div EX occupancy,
// taken-branch flushes, plus a saturating count of cycles in which the PC was held.
module hazard_stall_unit #(
  parameter int R_WIDTH    = 5,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [R_WIDTH-1:0]   id_rs_i,
  input  logic [R_WIDTH-1:0]   id_rt_i,
  input  logic                 id_uses_rt_i,
  input  logic                 id_muldiv_i,
  input  logic [R_WIDTH-1:0]   ex_rd_i,
  input  logic                 ex_mem_read_i,
  input  logic                 ex_branch_taken_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
  output logic                 ex_hold_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, next_state;
  logic [7:0] cnt, next_cnt;
  logic       load_use;

  // Register 0 is hard-wired, so a load "to" r0 never creates a dependency.
  assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_hold_o     = 1'b0;
    busy_o        = 1'b0;
    next_state    = state;
    next_cnt      = cnt;
    unique case (state)
      IDLE: begin
        if (ex_branch_taken_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (load_use) begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_flush_o = 1'b1;
        end else if (id_muldiv_i && (DIV_CYCLES > 1)) begin
          // The mult/div enters EX next cycle; it has DIV_CYCLES-1 cycles left after that.
          next_state = BUSY;
          next_cnt   = 8'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        ex_hold_o     = 1'b1;
        busy_o        = 1'b1;
        next_cnt      = cnt - 8'd1;
        if (cnt == 8'd1) begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (!pc_write_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (default and CNT_WIDTH=4/DIV_CYCLES=1) on shared
// stimulus, compared every cycle against a cycles-remaining model, plus directed literal checks.
module tb_hazard_stall_unit;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rt = 1'b0, id_muldiv = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;

  logic        pc_w  [2];
  logic        ifid_w[2];
  logic        ifid_f[2];
  logic        idex_f[2];
  logic        hold  [2];
  logic        busy  [2];
  logic [15:0] scnt0;
  logic [3:0]  scnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.R_WIDTH(RW), .DIV_CYCLES(8), .CNT_WIDTH(16)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .id_muldiv_i(id_muldiv), .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
    .ex_branch_taken_i(ex_branch_taken), .pc_write_o(pc_w[0]), .if_id_write_o(ifid_w[0]),
    .if_id_flush_o(ifid_f[0]), .id_ex_flush_o(idex_f[0]), .ex_hold_o(hold[0]), .busy_o(busy[0]),
    .stall_cnt_o(scnt0));

  hazard_stall_unit #(.R_WIDTH(RW), .DIV_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .id_muldiv_i(id_muldiv), .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read),
    .ex_branch_taken_i(ex_branch_taken), .pc_write_o(pc_w[1]), .if_id_write_o(ifid_w[1]),
    .if_id_flush_o(ifid_f[1]), .id_ex_flush_o(idex_f[1]), .ex_hold_o(hold[1]), .busy_o(busy[1]),
    .stall_cnt_o(scnt1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by "cycles of EX occupancy still to come" and a stall total.
  int div_cycles[2] = '{8, 1};
  int cnt_max   [2] = '{65535, 15};
  int m_left [2];
  int m_cnt  [2];
  int n_left [2];
  int n_cnt  [2];
  bit n_valid = 1'b0;
  bit dut1_busy_seen = 1'b0;

  function automatic bit model_load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // Packed as {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold, busy}.
  function automatic logic [5:0] model_outs(input int left);
    if (left > 0)           return 6'b00_00_11;
    if (ex_branch_taken)    return 6'b11_11_00;
    if (model_load_use())   return 6'b00_01_00;
    return 6'b11_00_00;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic [5:0] exp_o, act_o;
        exp_o = model_outs(m_left[k]);
        act_o = {pc_w[k], ifid_w[k], ifid_f[k], idex_f[k], hold[k], busy[k]};
        check(k == 0 ? "outs_dut0" : "outs_dut1", 32'(act_o), 32'(exp_o));
        check(k == 0 ? "cnt_dut0" : "cnt_dut1", (k == 0) ? 32'(scnt0) : 32'(scnt1), 32'(m_cnt[k]));
        if (m_left[k] > 0)
          n_left[k] = m_left[k] - 1;
        else if (!ex_branch_taken && !model_load_use() && id_muldiv && div_cycles[k] > 1)
          n_left[k] = div_cycles[k] - 1;
        else
          n_left[k] = 0;
        n_cnt[k] = exp_o[5] ? m_cnt[k] : ((m_cnt[k] + 1 > cnt_max[k]) ? cnt_max[k] : m_cnt[k] + 1);
      end
      n_valid = 1'b1;
      if (busy[1]) dut1_busy_seen = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = '{0, 0};
      m_cnt   = '{0, 0};
      n_valid = 1'b0;
    end else if (n_valid) begin
      m_left  = n_left;
      m_cnt   = n_cnt;
      n_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int rs, input int rt, input bit urt, input bit md,
                        input int rd, input bit mr, input bit br);
    id_rs = RW'(rs); id_rt = RW'(rt); id_uses_rt = urt; id_muldiv = md;
    ex_rd = RW'(rd); ex_mem_read = mr; ex_branch_taken = br;
  endtask

  task automatic clear_in();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int busy_cycles;
    logic [15:0] s0;

    clear_in();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_pc_write", 32'(pc_w[0]), 32'd1);
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_stall_cnt", 32'(scnt0), 32'd0);

    // Single load-use stall
    next_cycle();
    set_in(5, 0, 0, 0, 5, 1, 0);
    @(negedge clk);
    check("lu_pc_write", 32'(pc_w[0]), 32'd0);
    check("lu_if_id_write", 32'(ifid_w[0]), 32'd0);
    check("lu_id_ex_flush", 32'(idex_f[0]), 32'd1);
    next_cycle();
    clear_in();
    @(negedge clk);
    check("lu_after_pc_write", 32'(pc_w[0]), 32'd1);
    check("lu_after_cnt", 32'(scnt0), 32'd1);

    // Non-hazards: load to r0, rt match without rt use
    next_cycle();
    set_in(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("r0_no_stall", 32'(pc_w[0]), 32'd1);
    next_cycle();
    set_in(1, 7, 0, 0, 7, 1, 0);
    @(negedge clk);
    check("rt_unused_no_stall", 32'(pc_w[0]), 32'd1);
    next_cycle();
    clear_in();
    @(negedge clk);
    check("nohaz_cnt", 32'(scnt0), 32'd1);

    // Mult/div occupancy: exactly 7 BUSY cycles
    next_cycle();
    set_in(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("md_entry_busy", 32'(busy[0]), 32'd0);
    s0 = scnt0;
    next_cycle();
    clear_in();
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy[0] && hold[0]) busy_cycles++;
      next_cycle();
    end
    @(negedge clk);
    check("md_busy_cycles", 32'(busy_cycles), 32'd7);
    check("md_stall_delta", 32'(scnt0 - s0), 32'd7);

    // Branch beats load-use and mult/div
    next_cycle();
    set_in(3, 0, 0, 1, 3, 1, 1);
    @(negedge clk);
    check("br_if_id_flush", 32'(ifid_f[0]), 32'd1);
    check("br_id_ex_flush", 32'(idex_f[0]), 32'd1);
    check("br_pc_write", 32'(pc_w[0]), 32'd1);
    s0 = scnt0;
    next_cycle();
    clear_in();
    @(negedge clk);
    check("br_no_busy", 32'(busy[0]), 32'd0);
    check("br_cnt_same", 32'(scnt0), 32'(s0));

    // Branch during BUSY is ignored
    next_cycle();
    set_in(0, 0, 0, 1, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("busy_br_flush", 32'(ifid_f[0]), 32'd0);
    check("busy_br_busy", 32'(busy[0]), 32'd1);
    next_cycle();
    clear_in();
    repeat (8) next_cycle();

    // Async reset mid-BUSY
    set_in(0, 0, 0, 1, 0, 0, 0);
    next_cycle();
    clear_in();
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_hold", 32'(hold[0]), 32'd0);
    check("arst_pc_write", 32'(pc_w[0]), 32'd1);
    check("arst_cnt", 32'(scnt0), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_after_busy", 32'(busy[0]), 32'd0);

    // 20 consecutive load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      set_in(9, 0, 0, 0, 9, 1, 0);
    end
    next_cycle();
    clear_in();
    @(negedge clk);
    check("sat_cnt4", 32'(scnt1), 32'd15);
    check("sat_cnt16", 32'(scnt0), 32'd20);

    // Randomized traffic with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if ($urandom_range(0, 399) == 0) begin
        clear_in();
        #1 rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
      end
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 6) == 0));
    end
    next_cycle();
    clear_in();
    @(negedge clk);
    check("dut1_never_busy", 32'(dut1_busy_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline stall and flush controller in the ID stage. It complements the forwarding unit by handling the hazards forwarding cannot cover:
- load-use dependencies, where data is not yet available from MEM;
- multi-cycle mult/div occupancy of EX;
- taken-branch flushes.

It drives the PC/IF-ID write enables, the IF-ID and ID-EX flushes, and an EX hold. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
R_WIDTH, 5, register-index width (matches `R_WIDTH).
DIV_CYCLES, 8, total cycles a mult/div instruction occupies EX; legal range 1..255.
CNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
id_rs_i  in  R_WIDTH  rs index of the instruction in ID.
id_rt_i  in  R_WIDTH  rt index of the instruction in ID.
id_uses_rt_i  in  1  the ID instruction reads rt as a source.
id_muldiv_i  in  1  the ID instruction is mult/div.
ex_rd_i  in  R_WIDTH  destination index of the instruction in EX.
ex_mem_read_i  in  1  the EX instruction is a load.
ex_branch_taken_i  in  1  a branch resolved taken in EX this cycle.
pc_write_o  out  1  PC update enable.
if_id_write_o  out  1  IF/ID register write enable.
if_id_flush_o  out  1  zero IF/ID (insert bubble).
id_ex_flush_o  out  1  zero ID/EX control (insert bubble).
ex_hold_o  out  1  freeze ID/EX and EX-stage state.
busy_o  out  1  the mult/div occupancy FSM is active.
stall_cnt_o  out  CNT_WIDTH  count of cycles with pc_write_o=0; saturates.

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, cnt=0, stall_cnt_o=0.
  - Outputs: pc_write_o=1, if_id_write_o=1, if_id_flush_o=0, id_ex_flush_o=0, ex_hold_o=0, busy_o=0.
  - Reset asserted in BUSY returns to IDLE immediately; no residual stall after release.
- load_use = ex_mem_read_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs_i) | (id_uses_rt_i & (ex_rd_i==id_rt_i))).
- FSM states: IDLE, BUSY. Outputs are combinational from state plus inputs. State, cnt and stall_cnt are registered.
- IDLE, priority 1, ex_branch_taken_i=1:
  - if_id_flush_o=1, id_ex_flush_o=1, pc_write_o=1, if_id_write_o=1.
  - load_use and id_muldiv_i are ignored (the ID instruction is squashed); stay IDLE.
- IDLE, priority 2, load_use=1:
  - pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, if_id_flush_o=0.
  - Exactly one stall cycle per load; the next cycle the load is in MEM and forwarding resolves it. Stay IDLE.
- IDLE, priority 3, id_muldiv_i=1 and DIV_CYCLES>1:
  - Outputs are the normal advance values.
  - Next state BUSY with cnt=DIV_CYCLES-1, because the instruction enters EX next cycle.
- IDLE otherwise: all outputs at reset values; stay IDLE.
- BUSY:
  - pc_write_o=0, if_id_write_o=0, ex_hold_o=1, busy_o=1, both flushes 0.
  - cnt decrements each cycle; at cnt==1, next state is IDLE.
  - BUSY therefore lasts exactly DIV_CYCLES-1 cycles.
  - ex_branch_taken_i, load_use and id_muldiv_i are ignored in BUSY; ID is frozen and re-evaluated in the first IDLE cycle.
- Back-to-back mult/div: the second is evaluated in the first IDLE cycle after BUSY and re-enters BUSY the following cycle.
- DIV_CYCLES==1: BUSY is never entered; mult/div behaves as a single-cycle op.
- stall_cnt_o increments on every clock where pc_write_o==0 (load stall or BUSY); it holds at all-ones.
- Exactly one of {branch flush, load stall, muldiv entry, BUSY, normal} applies per cycle.

Test Plan:
1. Reset release, then ex_mem_read_i=1, ex_rd_i=5, id_rs_i=5 for one cycle -> that cycle pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; next cycle (inputs cleared) all outputs normal; stall_cnt_o=1.
2. ex_rd_i=0 load with id_rs_i=0; then ex_rd_i=7, id_rt_i=7, id_uses_rt_i=0 -> no stall in either case; stall_cnt_o stays 0.
3. DIV_CYCLES=8, id_muldiv_i=1 for one cycle in IDLE -> busy_o=1 and ex_hold_o=1 for exactly 7 cycles starting next cycle, then IDLE; stall_cnt_o=7.
4. ex_branch_taken_i=1 together with load_use=1 and id_muldiv_i=1 -> both flushes 1, pc_write_o=1, no BUSY entry, stall_cnt_o unchanged. ex_branch_taken_i=1 during BUSY -> ignored.
5. rst_n_i pulsed low at BUSY cycle 3, asynchronously mid-cycle -> outputs return to reset values before the next edge; state IDLE; stall_cnt_o=0.
6. CNT_WIDTH=4, 20 consecutive load-use stalls -> stall_cnt_o saturates at 15. DIV_CYCLES=1 with id_muldiv_i=1 -> busy_o never asserts.
